// File: rtl/zmeas_pkg.sv
// Shared definitions for the impedance-measurement sequencer:
// state encoding, default settle time, index/stimulus widths and
// the bit position of the electrode-mux bank select.
package zmeas_pkg;

    localparam int DEF_SETTLE_CYCLES = 64;
    localparam int ELEC_W            = 8;
    localparam int STIM_W            = 16;
    localparam int SETTLE_W          = 16;
    localparam int SEL_LSB           = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_STIM    = 2'd2,
        ST_ADVANCE = 2'd3
    } state_e;

endpackage

// File: rtl/zmeas_sequencer_if.sv
// Control/status bundle between the sweep controller (master) and the
// impedance-measurement sequencer (slave). Clock and reset stay outside.
interface zmeas_sequencer_if #(
    parameter int ELEC_W = zmeas_pkg::ELEC_W,
    parameter int STIM_W = zmeas_pkg::STIM_W
);
    logic              start;
    logic              stop;
    logic              spi_receiving;
    logic [STIM_W-1:0] stim_cycles;
    logic [ELEC_W-1:0] elec_first;
    logic [ELEC_W-1:0] elec_last;
    logic              z_meas_trig;
    logic [1:0]        sel;
    logic [ELEC_W-1:0] elec_idx;
    logic              busy;
    logic              elec_done;
    logic              sweep_done;

    modport master (
        output start, stop, spi_receiving, stim_cycles, elec_first, elec_last,
        input  z_meas_trig, sel, elec_idx, busy, elec_done, sweep_done
    );

    modport slave (
        input  start, stop, spi_receiving, stim_cycles, elec_first, elec_last,
        output z_meas_trig, sel, elec_idx, busy, elec_done, sweep_done
    );
endinterface

// File: rtl/zmeas_cycle_counter.sv
// Loadable up-counter with synchronous clear, count enable and a flag
// that is high while the count equals the supplied limit.
module zmeas_cycle_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         at_limit
);
    logic [W-1:0] count_r;

    // Count register: clear beats load beats enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (en) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign at_limit = (count_r == limit);
endmodule

// File: rtl/zmeas_sequencer.sv
// Impedance-measurement sequencer: walks an electrode range, settles the
// mux, then gates the Z-measure SPI master's stimulus around recording
// bursts so that each electrode gets exactly stim_len active cycles.
// Optional feature macro: ZMEAS_CONTINUOUS_EN (wrap to the first
// electrode forever instead of returning to IDLE after the last one).
module zmeas_sequencer #(
    parameter int SETTLE_CYCLES = zmeas_pkg::DEF_SETTLE_CYCLES,
    parameter int ELEC_W        = zmeas_pkg::ELEC_W,
    parameter int STIM_W        = zmeas_pkg::STIM_W
) (
    input  logic               div_clk,
    input  logic               rst_state,
    zmeas_sequencer_if.slave   bus
);
    import zmeas_pkg::*;

    state_e            state_r, state_n;
    logic              trig_r, trig_n;
    logic              elec_done_r, elec_done_n;
    logic              sweep_done_r, sweep_done_n;
    logic              busy_r;
    logic [1:0]        sel_r;
    logic [ELEC_W-1:0] idx_r, idx_n;
    logic [ELEC_W-1:0] last_r, last_n;
    logic [STIM_W-1:0] len_r, len_n;
`ifdef ZMEAS_CONTINUOUS_EN
    logic [ELEC_W-1:0] first_r, first_n;
`endif
    logic              settle_clr_s, settle_en_s, settle_at_lim_s;
    logic              act_clr_s, act_en_s, act_at_lim_s;

    zmeas_cycle_counter #(.W(SETTLE_W)) u_settle_cnt (
        .clk      (div_clk),
        .rst      (rst_state),
        .clr      (settle_clr_s),
        .load     (1'b0),
        .load_val ({SETTLE_W{1'b0}}),
        .en       (settle_en_s),
        .limit    (SETTLE_W'(SETTLE_CYCLES - 1)),
        .at_limit (settle_at_lim_s)
    );

    // The active counter counts stimulus cycles as they are issued, so
    // reaching stim_len means the last high cycle is already on the wire.
    zmeas_cycle_counter #(.W(STIM_W)) u_act_cnt (
        .clk      (div_clk),
        .rst      (rst_state),
        .clr      (act_clr_s),
        .load     (1'b0),
        .load_val ({STIM_W{1'b0}}),
        .en       (act_en_s),
        .limit    (len_r),
        .at_limit (act_at_lim_s)
    );

    // Next-state and next-output decode; stop overrides everything.
    always_comb begin
        state_n      = state_r;
        trig_n       = 1'b0;
        elec_done_n  = 1'b0;
        sweep_done_n = 1'b0;
        idx_n        = idx_r;
        last_n       = last_r;
        len_n        = len_r;
        settle_clr_s = 1'b0;
        settle_en_s  = 1'b0;
        act_clr_s    = 1'b0;
        act_en_s     = 1'b0;
`ifdef ZMEAS_CONTINUOUS_EN
        first_n      = first_r;
`endif
        if (bus.stop) begin
            state_n = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_n      = ST_SETTLE;
                        len_n        = (bus.stim_cycles == {STIM_W{1'b0}}) ? STIM_W'(1) : bus.stim_cycles;
                        idx_n        = bus.elec_first;
                        last_n       = (bus.elec_last < bus.elec_first) ? bus.elec_first : bus.elec_last;
                        settle_clr_s = 1'b1;
`ifdef ZMEAS_CONTINUOUS_EN
                        first_n      = bus.elec_first;
`endif
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    settle_en_s = 1'b1;
                    if (settle_at_lim_s) begin
                        state_n   = ST_STIM;
                        act_clr_s = 1'b1;
                    end else begin
                        state_n = ST_SETTLE;
                    end
                end
                ST_STIM: begin
                    if (act_at_lim_s) begin
                        state_n      = ST_ADVANCE;
                        elec_done_n  = 1'b1;
                        sweep_done_n = (idx_r == last_r);
                    end else begin
                        trig_n   = !bus.spi_receiving;
                        act_en_s = !bus.spi_receiving;
                    end
                end
                ST_ADVANCE: begin
                    settle_clr_s = 1'b1;
                    if (idx_r == last_r) begin
`ifdef ZMEAS_CONTINUOUS_EN
                        idx_n   = first_r;
                        state_n = ST_SETTLE;
`else
                        state_n = ST_IDLE;
`endif
                    end else begin
                        idx_n   = idx_r + ELEC_W'(1);
                        state_n = ST_SETTLE;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge div_clk or posedge rst_state) begin
        if (rst_state) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Registered outputs and sampled sweep parameters.
    always_ff @(posedge div_clk or posedge rst_state) begin
        if (rst_state) begin
            trig_r       <= 1'b0;
            elec_done_r  <= 1'b0;
            sweep_done_r <= 1'b0;
            busy_r       <= 1'b0;
            sel_r        <= 2'b00;
            idx_r        <= {ELEC_W{1'b0}};
            last_r       <= {ELEC_W{1'b0}};
            len_r        <= {STIM_W{1'b0}};
`ifdef ZMEAS_CONTINUOUS_EN
            first_r      <= {ELEC_W{1'b0}};
`endif
        end else begin
            trig_r       <= trig_n;
            elec_done_r  <= elec_done_n;
            sweep_done_r <= sweep_done_n;
            busy_r       <= (state_n != ST_IDLE);
            sel_r        <= idx_n[SEL_LSB +: 2];
            idx_r        <= idx_n;
            last_r       <= last_n;
            len_r        <= len_n;
`ifdef ZMEAS_CONTINUOUS_EN
            first_r      <= first_n;
`endif
        end
    end

    assign bus.z_meas_trig = trig_r;
    assign bus.elec_done   = elec_done_r;
    assign bus.sweep_done  = sweep_done_r;
    assign bus.busy        = busy_r;
    assign bus.sel         = sel_r;
    assign bus.elec_idx    = idx_r;
endmodule

// File: doc/zmeas_sequencer.md
# zmeas_sequencer

Sweeps impedance measurement across an electrode range and schedules the measurement datapath around recording traffic. It sequences the Z-measure SPI master's `z_meas_trig` once per electrode and drives the electrode mux select. It pauses stimulus whenever the recording SPI master asserts `spi_receiving`, so recording always has priority. It sits between the recording SPI master and the Z-measure SPI master inside the 256-channel AFE top level.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 64: `div_clk` cycles after each electrode/select change before stimulus starts (valid 1..65535).
- `ELEC_W`, default 8: electrode index width (256 electrodes).
- `STIM_W`, default 16: stimulus cycle count width.

Ports:
- `div_clk`  in  1  block clock.
- `rst_state`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begins a sweep; honoured only in IDLE.
- `stop`  in  1  abort; overrides all other inputs.
- `spi_receiving`  in  1  recording burst active; stimulus pauses while high.
- `stim_cycles`  in  STIM_W  active stimulus cycles per electrode; sampled at start; 0 is treated as 1.
- `elec_first`, `elec_last`  in  ELEC_W each  sweep bounds; sampled at start.
- `z_meas_trig`  out  1  stimulus enable to the Z-measure SPI master.
- `sel`  out  2  mux bank select, equal to `elec_idx[7:6]`.
- `elec_idx`  out  ELEC_W  current electrode.
- `busy`  out  1  high in every state except IDLE.
- `elec_done`  out  1  one-cycle pulse when an electrode's stimulus completes.
- `sweep_done`  out  1  one-cycle pulse at the end of the sweep.

## Operation
- States: IDLE, SETTLE, STIM, ADVANCE. All outputs are registered.
- IDLE → SETTLE on `start`:
  - latch `stim_cycles` as `stim_len` (0 becomes 1);
  - latch `elec_first` into `elec_idx`;
  - latch `elec_last` into `last_r`; if `elec_last < elec_first`, `last_r = elec_first`, so a single electrode is measured;
  - clear the settle counter.
- SETTLE:
  - `z_meas_trig` = 0.
  - The counter increments every cycle regardless of `spi_receiving`.
  - After `SETTLE_CYCLES` cycles → STIM, with the active counter cleared.
- STIM:
  - Each edge: `z_meas_trig <= !spi_receiving && (act_cnt < stim_len)`.
  - `act_cnt` increments in each cycle where `z_meas_trig` is high.
  - When `act_cnt` reaches `stim_len`, `z_meas_trig` drops at that edge → ADVANCE.
  - Exactly `stim_len` high cycles per electrode, whatever the pauses.
- ADVANCE (one cycle):
  - `elec_done` = 1.
  - If `elec_idx == last_r`: `sweep_done` = 1 → IDLE.
  - Otherwise: `elec_idx + 1` → SETTLE.
  - `sel` follows the new index in the same edge.
- `stop` in any state: next edge → IDLE, `z_meas_trig` = 0, no `elec_done` or `sweep_done`, `elec_idx` holds its value.
- `start` while busy is ignored. `start` and `stop` asserted together in IDLE: stop wins, state stays IDLE.
- Arithmetic:
  - `act_cnt` is STIM_W bits and compares against `stim_len`, so it cannot overflow.
  - `elec_idx` increment never wraps, because `last_r` ≤ 255.
  - Settle counter is 16 bits.

## Timing
- Reset values: state IDLE; `z_meas_trig`, `busy`, `elec_done`, `sweep_done` = 0; `elec_idx` = 0; `sel` = 0. Reset mid-sweep is immediate and asynchronous.
- `start` high at edge k → `busy` = 1 after edge k.
- First `z_meas_trig` high after edge k + `SETTLE_CYCLES` + 1, if `spi_receiving` is low.
- `spi_receiving` rising at edge n → `z_meas_trig` low after edge n. Falling at edge m → `z_meas_trig` high after edge m.
- Per-electrode time with no pauses: `SETTLE_CYCLES` + `stim_len` + 2 cycles (settle, stimulus, final STIM edge, ADVANCE).
- `elec_done` and `sweep_done` are asserted in the same cycle.

## Configuration
- `ZMEAS_CONTINUOUS_EN` defined:
  - ADVANCE at `last_r` reloads `elec_first` (the sampled copy) and returns to SETTLE instead of IDLE.
  - `sweep_done` still pulses at each wrap.
  - The sweep ends only on `stop` or reset.
- Not defined: a single sweep, then IDLE.

## Structure
- Shared package `zmeas_pkg` holds:
  - state enum (IDLE = 0, SETTLE = 1, STIM = 2, ADVANCE = 3);
  - default `SETTLE_CYCLES`;
  - widths `ELEC_W`/`STIM_W`;
  - `SEL_LSB` = 6.
- One sub-module, `zmeas_cycle_counter`: a loadable up-counter with clear, enable and `== limit` flag. It is instanced twice, for settle and active counts.

## Test plan
- `elec_first`=0, `elec_last`=3, `stim_cycles`=10, `SETTLE_CYCLES`=4, `spi_receiving`=0 → 4 `elec_done` pulses, 10 `z_meas_trig` high cycles each, 16 cycles per electrode, `sweep_done` with `elec_idx`=3.
- Same setup, `spi_receiving` high 3 cycles in every 8 → still exactly 10 high cycles per electrode; `z_meas_trig` never high while `spi_receiving` was high at the prior edge.
- `elec_first`=62, `elec_last`=65 → `sel` goes 0, 0, 1, 1 as `elec_idx` goes 62→65.
- `stim_cycles`=0 → exactly 1 high cycle per electrode. `elec_last`=5, `elec_first`=9 → only electrode 9 is measured.
- `stop` during STIM at electrode 2 → IDLE next cycle, `z_meas_trig` 0, no done pulses. `rst_state` mid-SETTLE → all outputs at reset values immediately.
- With `ZMEAS_CONTINUOUS_EN`, range 0..1 → `elec_idx` goes 0, 1, 0, 1…, `sweep_done` at each wrap, `busy` stays 1 until `stop`.
